frame_minmax_tracker: RTL
=========================

# frame_minmax_tracker

Streaming stage that consumes a stream of unsigned 8-bit samples over a valid/ready handshake and, per frame of FRAME_LEN samples, reports the maximum, the minimum, and the in-frame index of each. It applies the unsigned magnitude-compare rule (greater / equal / less) sequentially against the running extremes. It sits directly downstream of the unsigned comparator stage in the datapath and presents one registered result per frame to the next consumer.

## Interface
- WIDTH, 8: sample width, unsigned.
- FRAME_LEN, 16: samples per frame, ≥1.
- IDX_W (localparam): max(1, clog2(FRAME_LEN)).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort: discards partial frame and pending result.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- in_data  in  WIDTH  sample, unsigned.
- out_valid  out  1  frame result available.
- out_ready  in  1  consumer accepts result.
- out_max  out  WIDTH  frame maximum.
- out_min  out  WIDTH  frame minimum.
- out_max_idx  out  IDX_W  index (0-based, arrival order) of the maximum.
- out_min_idx  out  IDX_W  index of the minimum.

## Operation
- FSM states:
  - IDLE: waiting for the first sample of a frame.
  - ACC: accumulating.
  - HOLD: result presented.
- Accept = in_valid & in_ready. in_ready = 1 in IDLE and ACC, 0 in HOLD.
- IDLE + accept: max = min = in_data; both idx = 0; cnt = 1. Next state is ACC, or HOLD if FRAME_LEN == 1.
- ACC + accept:
  - If in_data > max: max = in_data, max_idx = cnt.
  - If in_data < min: min = in_data, min_idx = cnt.
  - Equality never updates (first occurrence wins).
  - cnt increments. The accept making cnt == FRAME_LEN moves the FSM to HOLD.
- Compare is unsigned over the full WIDTH; no sign extension, no saturation.
- HOLD: out_valid = 1 and outputs stay stable until out_ready. On out_valid & out_ready, go to IDLE and clear cnt.
- clear (sync, highest priority): next state IDLE, cnt = 0, out_valid = 0. Any accept or output handshake in the same cycle is void.
- rst (async): state IDLE, cnt = 0, out_valid = 0, out_max/out_min/idx = 0. in_ready follows state (1), but no sample is counted while rst is high.

## Timing
- out_valid rises on the clock edge that accepts the FRAME_LEN-th sample, i.e. visible the cycle after the final accept. Latency is 1 cycle.
- Result registers update only in IDLE/ACC. They are frozen in HOLD.
- No overlap: the first sample of the next frame is accepted no earlier than the cycle after the output handshake.
- With a zero-stall stream and out_ready tied high, throughput is FRAME_LEN samples per FRAME_LEN+1 cycles.
- in_valid in HOLD is ignored. in_data may change freely when not accepted.
- Reset deassertion mid-frame: restart from IDLE; no partial result is emitted.

## Configuration
- FRAME_MINMAX_TIE_LAST_EN:
  - Defined: ties update the index, so max updates on in_data ≥ max and min updates on in_data ≤ min (the last occurrence is reported). Values are unchanged.
  - Undefined (default): first occurrence is reported, as in Operation.

## Test plan
- Ascending frame 0x00..0x0F (FRAME_LEN=16, out_ready=1) -> out_max=0x0F, idx 15; out_min=0x00, idx 0. out_valid is high exactly one cycle, the cycle after the 16th accept.
- All 16 samples 0x80 -> max=min=0x80, both idx 0. With FRAME_MINMAX_TIE_LAST_EN, both idx 15.
- Extremes: sample 3 = 0x00, sample 7 = 0xFF, the rest 0x55 -> max 0xFF idx 7, min 0x00 idx 3. This confirms the unsigned compare (0xFF is not treated as −1).
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, no sample consumed. After out_ready=1 for one cycle, the next frame starts at index 0 with fresh extremes.
- clear asserted after 9 accepts -> out_valid stays 0. The next 16 samples form a complete frame; earlier samples do not influence it.
- Assert rst asynchronously mid-frame (between edges) -> out_valid and all outputs go to 0 immediately. After release, a full new frame is required for a result.

Source files
------------

// File: rtl/frame_minmax_tracker.sv
// Per-frame running max/min (with in-frame indices) over a valid/ready sample stream.
// Optional FRAME_MINMAX_TIE_LAST_EN: ties move the index to the latest occurrence.
module frame_minmax_tracker #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAME_LEN = 16,
  localparam int unsigned IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [IDX_W-1:0] out_max_idx,
  output logic [IDX_W-1:0] out_min_idx
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_max;
  logic [WIDTH-1:0]   r_min;
  logic [IDX_W-1:0]   r_max_idx;
  logic [IDX_W-1:0]   r_min_idx;
  logic               r_out_valid;

  logic               w_max_upd;
  logic               w_min_upd;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_last;

  always_comb begin
`ifdef FRAME_MINMAX_TIE_LAST_EN
    w_max_upd = (in_data >= r_max);
    w_min_upd = (in_data <= r_min);
`else
    w_max_upd = (in_data > r_max);
    w_min_upd = (in_data < r_min);
`endif
    w_cnt_nxt = r_cnt + CNT_W'(1);
    w_last    = (w_cnt_nxt == CNT_W'(FRAME_LEN));
  end

  // out_valid is kept as its own flop so it is glitch-free to the consumer; it tracks HOLD exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_max       <= '0;
      r_min       <= '0;
      r_max_idx   <= '0;
      r_min_idx   <= '0;
      r_out_valid <= 1'b0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_max     <= in_data;
            r_min     <= in_data;
            r_max_idx <= '0;
            r_min_idx <= '0;
            r_cnt     <= CNT_W'(1);
            if (FRAME_LEN == 1) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ACC;
            end
          end
        end
        ACC: begin
          if (in_valid) begin
            if (w_max_upd) begin
              r_max     <= in_data;
              r_max_idx <= IDX_W'(r_cnt);
            end
            if (w_min_upd) begin
              r_min     <= in_data;
              r_min_idx <= IDX_W'(r_cnt);
            end
            r_cnt <= w_cnt_nxt;
            if (w_last) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = (r_state != HOLD);
  assign out_valid   = r_out_valid;
  assign out_max     = r_max;
  assign out_min     = r_min;
  assign out_max_idx = r_max_idx;
  assign out_min_idx = r_min_idx;

endmodule
